// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with writeback bypass, load-use interlock and the decode->execute pipeline register.
// Latency: one cycle from an accepted decode instruction (ValidD & ReadyD) to ValidE carrying it.
// Backpressure: ReadyD drops while execute holds (ValidE & ~ReadyE) or on a load-use hazard; FlushE forces it high.
// Ports: clk/rst; decode side ValidD, InstrD, PCD, PCPlus4D, ImmExtD, CtrlD -> ReadyD;
//        writeback RegWriteW/RDW/ResultW; execute handshake ReadyE, FlushE;
//        execute register ValidE, CtrlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E; StallCnt.
module decode_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,   // at most 32: index fields are 5 bits
    parameter int CTRL_W   = 12,
    parameter int LOAD_BIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidD,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic              RegWriteW,
    input  logic [4:0]        RDW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              ReadyE,
    input  logic              FlushE,
    output logic              ReadyD,
    output logic              ValidE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   Imm_Ext_E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [4:0]        RD_E,
    output logic [4:0]        RS1_E,
    output logic [4:0]        RS2_E,
    output logic [CNT_W-1:0]  StallCnt
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc4;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
    } ex_t;

    ex_t              ex_q;
    logic [XLEN-1:0]  rf [NREGS];
    logic [CNT_W-1:0] stall_cnt;

    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] rd1_d, rd2_d;
    logic            wb_en, hold, luh;
    logic            unused_instr;

    assign rs1_d = InstrD[19:15];
    assign rs2_d = InstrD[24:20];
    assign rd_d  = InstrD[11:7];
    assign unused_instr = ^{InstrD[31:25], InstrD[14:12], InstrD[6:0]};

    // x0 is never written, so the write enable alone keeps it zero.
    assign wb_en = RegWriteW && (RDW != 5'd0);

    // Write-first read: a same-cycle writeback to the read index wins over the array.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (wb_en && (RDW == rs1_d))
            rd1_d = ResultW;
        else if (rs1_d != 5'd0)
            rd1_d = rf[rs1_d];
        if (wb_en && (RDW == rs2_d))
            rd2_d = ResultW;
        else if (rs2_d != 5'd0)
            rd2_d = rf[rs2_d];
    end

    assign hold = ex_q.valid && !ReadyE;
    assign luh  = ValidD && ex_q.valid && ex_q.ctrl[LOAD_BIT] && (ex_q.rd != 5'd0)
               && ((ex_q.rd == rs1_d) || (ex_q.rd == rs2_d));

    // A flush kills whatever decode holds, so the instruction counts as consumed.
    assign ReadyD = !rst && (FlushE || (!hold && !luh));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (wb_en) begin
            rf[RDW] <= ResultW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (FlushE) begin
            ex_q.valid <= 1'b0;
            ex_q.ctrl  <= '0;
            ex_q.rd    <= '0;
        end else if (hold) begin
            // A held instruction still picks up results written back while it waits.
            if (wb_en && (RDW == ex_q.rs1))
                ex_q.rd1 <= ResultW;
            if (wb_en && (RDW == ex_q.rs2))
                ex_q.rd2 <= ResultW;
        end else if (luh || !ValidD) begin
            ex_q.valid <= 1'b0;
            ex_q.ctrl  <= '0;
            ex_q.rd    <= '0;
        end else begin
            ex_q.valid <= 1'b1;
            ex_q.ctrl  <= CtrlD;
            ex_q.rd1   <= rd1_d;
            ex_q.rd2   <= rd2_d;
            ex_q.imm   <= ImmExtD;
            ex_q.pc    <= PCD;
            ex_q.pc4   <= PCPlus4D;
            ex_q.rd    <= rd_d;
            ex_q.rs1   <= rs1_d;
            ex_q.rs2   <= rs2_d;
        end
    end

    // Counts only cycles where a bubble is actually inserted for a load-use hazard.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (luh && !hold && !FlushE && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign ValidE    = ex_q.valid;
    assign CtrlE     = ex_q.ctrl;
    assign RD1_E     = ex_q.rd1;
    assign RD2_E     = ex_q.rd2;
    assign Imm_Ext_E = ex_q.imm;
    assign PCE       = ex_q.pc;
    assign PCPlus4E  = ex_q.pc4;
    assign RD_E      = ex_q.rd;
    assign RS1_E     = ex_q.rs1;
    assign RS2_E     = ex_q.rs2;
    assign StallCnt  = stall_cnt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed stimulus pushes expected per-cycle state into a scoreboard queue;
// a monitor on the falling edge pops and compares. A second instance with a 2-bit counter checks saturation.
// Inputs are driven 1 time unit after the rising edge.
module tb_decode_stage_pipe;

    localparam logic [11:0] LD = 12'h010;
    localparam logic [11:0] AL = 12'h003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ValidD, RegWriteW, ReadyE, FlushE;
    logic [31:0] InstrD, PCD, PCPlus4D, ImmExtD, ResultW;
    logic [11:0] CtrlD;
    logic [4:0]  RDW;

    logic        ReadyD, ValidE;
    logic [11:0] CtrlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E, RS1_E, RS2_E;
    logic [15:0] StallCnt;

    logic        s_ReadyD, s_ValidE;
    logic [11:0] s_CtrlE;
    logic [31:0] s_RD1_E, s_RD2_E, s_Imm_Ext_E, s_PCE, s_PCPlus4E;
    logic [4:0]  s_RD_E, s_RS1_E, s_RS2_E;
    logic [1:0]  s_StallCnt;

    decode_stage_pipe dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ImmExtD(ImmExtD), .CtrlD(CtrlD), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .ReadyE(ReadyE), .FlushE(FlushE), .ReadyD(ReadyD), .ValidE(ValidE), .CtrlE(CtrlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E), .StallCnt(StallCnt)
    );

    decode_stage_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ImmExtD(ImmExtD), .CtrlD(CtrlD), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .ReadyE(ReadyE), .FlushE(FlushE), .ReadyD(s_ReadyD), .ValidE(s_ValidE), .CtrlE(s_CtrlE),
        .RD1_E(s_RD1_E), .RD2_E(s_RD2_E), .Imm_Ext_E(s_Imm_Ext_E), .PCE(s_PCE), .PCPlus4E(s_PCPlus4E),
        .RD_E(s_RD_E), .RS1_E(s_RS1_E), .RS2_E(s_RS2_E), .StallCnt(s_StallCnt)
    );

    typedef struct {
        logic        rdy, vld, pay;
        logic [11:0] ctl;
        logic [4:0]  rd, rs1, rs2;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic [31:0] rd1, rd2, imm, pc, pc4;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    task automatic drive(input logic r, input logic vd, input logic [31:0] ins, input logic [11:0] ctl,
                         input logic [31:0] pc, input logic [31:0] imm, input logic rw, input logic [4:0] rdw,
                         input logic [31:0] res, input logic re, input logic fl);
        rst = r; ValidD = vd; InstrD = ins; CtrlD = ctl; PCD = pc; PCPlus4D = pc + 32'd4;
        ImmExtD = imm; RegWriteW = rw; RDW = rdw; ResultW = res; ReadyE = re; FlushE = fl;
    endtask

    // Expected state visible during the current cycle: ReadyD for the inputs just driven,
    // E register as produced by the previous edge. Advances one cycle.
    task automatic sb_push(input string nm, input logic rdy, input logic vld, input logic [11:0] ctl,
                           input logic [4:0] rd, input logic [15:0] cnt, input logic pay,
                           input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [31:0] pc4, input logic [4:0] rs1,
                           input logic [4:0] rs2);
        exp_t e;
        e.rdy = rdy; e.vld = vld; e.ctl = ctl; e.rd = rd; e.cnt = cnt; e.pay = pay;
        e.cnt2 = (cnt > 16'd3) ? 2'd3 : cnt[1:0];
        e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.pc = pc; e.pc4 = pc4; e.rs1 = rs1; e.rs2 = rs2;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic sb_bub(input string nm, input logic rdy, input logic [15:0] cnt);
        sb_push(nm, rdy, 1'b0, 12'h0, 5'd0, cnt, 1'b0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    endtask

    // Monitor
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, " ReadyD"}, 32'(ReadyD), 32'(e.rdy));
                chk({nm, " ValidE"}, 32'(ValidE), 32'(e.vld));
                chk({nm, " CtrlE"}, 32'(CtrlE), 32'(e.ctl));
                chk({nm, " RD_E"}, 32'(RD_E), 32'(e.rd));
                chk({nm, " StallCnt"}, 32'(StallCnt), 32'(e.cnt));
                chk({nm, " StallCnt_w2"}, 32'(s_StallCnt), 32'(e.cnt2));
                chk({nm, " ValidE_w2"}, 32'(s_ValidE), 32'(e.vld));
                if (e.pay) begin
                    chk({nm, " RD1_E"}, RD1_E, e.rd1);
                    chk({nm, " RD2_E"}, RD2_E, e.rd2);
                    chk({nm, " Imm_Ext_E"}, Imm_Ext_E, e.imm);
                    chk({nm, " PCE"}, PCE, e.pc);
                    chk({nm, " PCPlus4E"}, PCPlus4E, e.pc4);
                    chk({nm, " RS1_E"}, 32'(RS1_E), 32'(e.rs1));
                    chk({nm, " RS2_E"}, 32'(RS2_E), 32'(e.rs2));
                end
            end
        end
    end

    initial begin
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog: stimulus did not complete, %0d checks done", n_assert);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_push("reset", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // add x1,x5,x0 while x5 is being written back
        drive(0, 1, mk(1, 5, 0), AL, 32'h100, 32'h11, 1, 5, 32'hDEADBEEF, 1, 0);
        sb_push("bypass_issue", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // write to x0 in the same cycle as reading it; x5 now comes from the array
        drive(0, 1, mk(2, 0, 5), AL, 32'h104, 32'h22, 1, 0, 32'h1234, 1, 0);
        sb_push("bypass_result", 1, 1, AL, 1, 0, 1, 32'hDEADBEEF, 0, 32'h11, 32'h100, 32'h104, 5, 0);
        // load x3 reading x0 after the x0 write
        drive(0, 1, mk(3, 0, 0), LD, 32'h108, 32'h44, 0, 0, 0, 1, 0);
        sb_push("x0_write_read", 1, 1, AL, 2, 0, 1, 0, 32'hDEADBEEF, 32'h22, 32'h104, 32'h108, 0, 5);
        // add x4,x3,x2 behind the load: stall
        drive(0, 1, mk(4, 3, 2), AL, 32'h10C, 32'h55, 0, 0, 0, 1, 0);
        sb_push("load_use_stall", 0, 1, LD, 3, 0, 1, 0, 0, 32'h44, 32'h108, 32'h10C, 0, 0);
        // bubble in E; load result written back and bypassed into the reissue
        drive(0, 1, mk(4, 3, 2), AL, 32'h10C, 32'h55, 1, 3, 32'hAAAA0003, 1, 0);
        sb_bub("load_use_bubble", 1, 1);
        drive(0, 1, mk(8, 1, 7), AL, 32'h110, 32'h66, 0, 0, 0, 1, 0);
        sb_push("load_use_reissue", 1, 1, AL, 4, 1, 1, 32'hAAAA0003, 0, 32'h55, 32'h10C, 32'h110, 3, 2);
        // hold with x7 written back: RD2_E refreshed
        drive(0, 1, mk(9, 7, 0), AL, 32'h114, 32'h77, 1, 7, 32'h55, 0, 0);
        sb_push("hold_issue", 0, 1, AL, 8, 1, 1, 0, 0, 32'h66, 32'h110, 32'h114, 1, 7);
        drive(0, 1, mk(9, 7, 0), AL, 32'h114, 32'h77, 0, 0, 0, 1, 0);
        sb_push("hold_refresh", 1, 1, AL, 8, 1, 1, 0, 32'h55, 32'h66, 32'h110, 32'h114, 1, 7);
        // flush while execute is holding
        drive(0, 1, mk(10, 9, 0), AL, 32'h118, 32'h88, 0, 0, 0, 0, 1);
        sb_push("flush_vs_hold", 1, 1, AL, 9, 1, 1, 32'h55, 0, 32'h77, 32'h114, 32'h118, 7, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        sb_bub("flush_result", 1, 1);
        // load x11, then dependent add while execute holds: hold wins
        drive(0, 1, mk(11, 0, 0), LD, 32'h200, 32'h0, 0, 0, 0, 1, 0);
        sb_bub("idle_bubble", 1, 1);
        drive(0, 1, mk(12, 11, 0), AL, 32'h204, 32'h0, 0, 0, 0, 0, 0);
        sb_push("luh_and_hold", 0, 1, LD, 11, 1, 1, 0, 0, 0, 32'h200, 32'h204, 0, 0);
        drive(0, 1, mk(12, 11, 0), AL, 32'h204, 32'h0, 0, 0, 0, 1, 0);
        sb_push("hold_wins", 0, 1, LD, 11, 1, 1, 0, 0, 0, 32'h200, 32'h204, 0, 0);
        drive(0, 1, mk(12, 11, 0), AL, 32'h204, 32'h0, 0, 0, 0, 1, 0);
        sb_bub("stall_after_hold", 1, 2);

        // three more load-use stalls: 16-bit counter reaches 5, 2-bit counter sticks at 3
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, mk(13, 0, 0), LD, 32'h300, 32'h0, 0, 0, 0, 1, 0);
            sb_push("sat_load", 1, 1, AL, (i == 0) ? 5'd12 : 5'd14, 16'(2 + i), 0, 0, 0, 0, 0, 0, 0, 0);
            drive(0, 1, mk(14, 13, 13), AL, 32'h304, 32'h0, 0, 0, 0, 1, 0);
            sb_push("sat_stall", 0, 1, LD, 13, 16'(2 + i), 0, 0, 0, 0, 0, 0, 0, 0);
            drive(0, 1, mk(14, 13, 13), AL, 32'h304, 32'h0, 0, 0, 0, 1, 0);
            sb_bub("sat_bubble", 1, 16'(3 + i));
        end

        // reset in the middle of a hold
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_push("pre_reset_hold", 0, 1, AL, 14, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_push("reset_mid_hold", 0, 1, AL, 14, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        // x5/x7 were cleared by reset
        drive(0, 1, mk(15, 5, 7), AL, 32'h400, 32'h99, 0, 0, 0, 0, 0);
        sb_push("post_reset", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        sb_push("post_reset_load", 1, 1, AL, 15, 0, 1, 0, 0, 32'h99, 32'h400, 32'h404, 5, 7);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        sb_bub("final_idle", 1, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
